regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised integer register file for the RISC-V core, with 2 combinational read ports and 2 synchronous write ports. Write port 0 is ALU writeback; write port 1 is load/memory writeback.
- Adds behaviour not present in the current register file:
  - hardwired-zero x0;
  - write-to-read bypass;
  - a per-register busy scoreboard with an issue handshake that stalls decode on RAW and WAW hazards against in-flight writes.
- Sits between decode/issue and the writeback stage.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2)
AW, $clog2(NREG), register address width
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/busy-set; 0 = register 0 is an ordinary register

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_reset  in  1  reset sys_reset, asynchronous, active-high
rs1_addr_i  in  AW  read port 1 address
rs2_addr_i  in  AW  read port 2 address
rs1_used_i  in  1  instruction consumes rs1 (enables hazard check)
rs2_used_i  in  1  instruction consumes rs2
rs1_data_o  out  XLEN  read port 1 data (combinational)
rs2_data_o  out  XLEN  read port 2 data (combinational)
wb0_en_i  in  1  write port 0 enable (ALU)
wb0_addr_i  in  AW  write port 0 address
wb0_data_i  in  XLEN  write port 0 data
wb1_en_i  in  1  write port 1 enable (load)
wb1_addr_i  in  AW  write port 1 address
wb1_data_i  in  XLEN  write port 1 data
issue_valid_i  in  1  decode presents an instruction
issue_rd_en_i  in  1  issuing instruction writes a destination register
issue_rd_i  in  AW  destination register of issuing instruction
issue_ready_o  out  1  no hazard; the issue is accepted this cycle when valid && ready
flush_i  in  1  pipeline flush; clears all busy bits
busy_vec_o  out  NREG  current scoreboard (registered)

Behaviour:
- Reset:
  - all registers = 0 and busy_vec_o = 0, asynchronously.
  - While sys_reset is high: rs1_data_o = rs2_data_o = 0, issue_ready_o = 0, and writes/issues are ignored.
  - Reset deasserted mid-operation: the state is simply the post-reset state; no partial write survives.
- Write:
  - On the rising edge, regs[wbN_addr] <= wbN_data when wbN_en is set.
  - Both ports enabled to the same address: wb1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read:
  - Combinational from the array, with same-cycle bypass: if wb1_en && wb1_addr==rsX_addr, output wb1_data; else if wb0_en && wb0_addr==rsX_addr, output wb0_data; else regs[rsX_addr].
  - With ZERO_REG=1, address 0 always outputs 0, including when a bypass matches.
- Effective busy (combinational): eff_busy[r] = busy[r] && !(wb0 or wb1 writes r this cycle). A same-cycle writeback therefore resolves the hazard with zero bubble, in combination with the bypass.
- issue_ready_o = !sys_reset && !flush_i && !(rs1_used && eff_busy[rs1]) && !(rs2_used && eff_busy[rs2]) && !(issue_rd_en && eff_busy[issue_rd]).
  - Hazards against register 0 never stall when ZERO_REG=1.
  - issue_ready_o does not depend on issue_valid_i.
- Scoreboard update (rising edge, in priority order):
  1. flush_i: all busy <= 0; any issue and writeback clears are irrelevant.
  2. Otherwise: clear busy[wb0_addr] if wb0_en, and clear busy[wb1_addr] if wb1_en.
  3. Then, if issue_valid && issue_ready && issue_rd_en, set busy[issue_rd]. Set wins over a same-cycle clear of the same register.
  - With ZERO_REG=1, busy[0] is never set.
- Flush does not alter register contents. Writebacks in the flush cycle still write the array.
- Writeback to a non-busy register is legal: the data is written and busy stays 0.
- Latency: write visible via bypass in the same cycle, and from the array from the next cycle. A busy bit set at edge N is visible in busy_vec_o after edge N.

Test Plan:
- Reset then read all addresses -> all 0, busy_vec_o=0, issue_ready_o=1 after deassert; x0 reads 0 after wb0 writes 0xDEADBEEF to addr 0.
- wb0 writes 0x00000011 and wb1 writes 0x00000022 to x5 in the same cycle, rs1_addr=5 -> rs1_data_o=0x22 in that cycle (bypass); 0x22 next cycle from the array.
- Issue rd=x7 (accepted); next cycle an instruction with rs2=x7, rs2_used=1 -> issue_ready_o=0 and busy_vec_o[7]=1. wb1 writes 0x1234 to x7 -> same cycle issue_ready_o=1 and rs2_data_o=0x1234; busy[7]=0 after the edge.
- WAW: x9 busy, issue with rd=x9 and no reads -> stalled until the wb0 clear. Same-cycle wb0 clear of x9 plus accepted issue rd=x9 -> busy[9] stays 1.
- x3, x4, x8 busy, then flush_i pulsed together with issue_valid and rd=x10 -> issue_ready_o=0, busy_vec_o=0 after the edge, x10 not busy, register data unchanged.
- Assert sys_reset asynchronously mid-cycle while x6 is busy and wb0_en targets x6 -> outputs 0 immediately; after release x6=0 and busy_vec_o=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file: 2 combinational read ports with writeback bypass, 2 write ports, busy scoreboard.
// Writes land on the next edge (bypassed same cycle); issue_ready_o stalls decode on RAW/WAW against in-flight writes.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic            sys_clk,
    input  logic            sys_reset,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic            rs1_used_i,
    input  logic            rs2_used_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            wb0_en_i,
    input  logic [AW-1:0]   wb0_addr_i,
    input  logic [XLEN-1:0] wb0_data_i,
    input  logic            wb1_en_i,
    input  logic [AW-1:0]   wb1_addr_i,
    input  logic [XLEN-1:0] wb1_data_i,
    input  logic            issue_valid_i,
    input  logic            issue_rd_en_i,
    input  logic [AW-1:0]   issue_rd_i,
    output logic            issue_ready_o,
    input  logic            flush_i,
    output logic [NREG-1:0] busy_vec_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] eff_busy;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            rd_haz;
    logic            issue_fire;

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Bypass priority mirrors the write priority: wb1 beats wb0 beats the array.
    function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (wb1_en_i && (wb1_addr_i == addr)) begin
            val = wb1_data_i;
        end else if (wb0_en_i && (wb0_addr_i == addr)) begin
            val = wb0_data_i;
        end else begin
            val = regs_q[addr];
        end
        if (sys_reset || is_zero(addr)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rs1_data_o = read_mux(rs1_addr_i);
    end

    always_comb begin
        rs2_data_o = read_mux(rs2_addr_i);
    end

    always_comb begin
        regs_d = regs_q;
        if (wb0_en_i && !is_zero(wb0_addr_i)) begin
            regs_d[wb0_addr_i] = wb0_data_i;
        end
        if (wb1_en_i && !is_zero(wb1_addr_i)) begin
            regs_d[wb1_addr_i] = wb1_data_i;
        end
    end

    always_comb begin
        wr_hit = '0;
        if (wb0_en_i) begin
            wr_hit[wb0_addr_i] = 1'b1;
        end
        if (wb1_en_i) begin
            wr_hit[wb1_addr_i] = 1'b1;
        end
    end

    // A writeback landing this cycle resolves the hazard: the bypass supplies the data.
    assign eff_busy = busy_q & ~wr_hit;

    always_comb begin
        rs1_haz       = rs1_used_i    && eff_busy[rs1_addr_i] && !is_zero(rs1_addr_i);
        rs2_haz       = rs2_used_i    && eff_busy[rs2_addr_i] && !is_zero(rs2_addr_i);
        rd_haz        = issue_rd_en_i && eff_busy[issue_rd_i] && !is_zero(issue_rd_i);
        issue_ready_o = !sys_reset && !flush_i && !rs1_haz && !rs2_haz && !rd_haz;
        issue_fire    = issue_valid_i && issue_ready_o && issue_rd_en_i && !is_zero(issue_rd_i);
    end

    // Set after clear so a same-cycle reissue of the same rd keeps it busy.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_fire) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule
